// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the core's memory controller (master) and the responder (slave).
// DATA_MEMORY_RESPONDER_RANGE_CHECK_EN adds the range_error return signal.
interface data_memory_responder_if;
    logic [31:0] addr;
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] din;
    logic [31:0] dout;
    logic        busy;
`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
    logic        range_error;

    modport master (output addr, ren, wen, din, input dout, busy, range_error);
    modport slave  (input addr, ren, wen, din, output dout, busy, range_error);
`else
    modport master (output addr, ren, wen, din, input dout, busy);
    modport slave  (input addr, ren, wen, din, output dout, busy);
`endif
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with programmable busy wait; completes each access in DONE.
// Optional DATA_MEMORY_RESPONDER_RANGE_CHECK_EN flags and suppresses out-of-range accesses.
//
// Handshake: a request (ren or any wen bit) is presented in IDLE; while busy is high the
// master holds its request, and the access completes in the cycle busy is low (DONE).
module data_memory_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    data_memory_responder_if.slave        bus,
    output logic [1:0]                    dbg_state
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam int         UPPER_W  = 32 - ADDR_WIDTH - 2;
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT4     = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [3:0]  wen_q, wen_d;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  active;
    logic                  show;
    logic                  out_of_range;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] idx_sel;
    logic [31:0]           wr_data;
    logic [3:0]            wr_mask;
    logic [UPPER_W-1:0]    upper;

    assign req = bus.ren | (|bus.wen);

    // Zero latency works straight off the live bus; otherwise the latched request is used.
    always_comb begin
        idx_sel = addr_q[ADDR_WIDTH+1:2];
        wr_data = din_q;
        wr_mask = wen_q;
        upper   = addr_q[31:ADDR_WIDTH+2];
        active  = (state_q == ST_DONE);
        show    = (state_q == ST_DONE);
        if (ZERO_LAT) begin
            idx_sel = bus.addr[ADDR_WIDTH+1:2];
            wr_data = bus.din;
            wr_mask = bus.wen;
            upper   = bus.addr[31:ADDR_WIDTH+2];
            active  = req;
            show    = 1'b1;
        end
    end

`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
    assign out_of_range    = active && (|upper) && !reset;
    assign bus.range_error = out_of_range;
`else
    logic unused_upper;
    assign out_of_range = 1'b0;
    assign unused_upper = ^upper;
`endif

    logic unused_low_bits;
    assign unused_low_bits = ^{bus.addr[1:0], addr_q[1:0]};

    assign commit    = active && !reset && !out_of_range;
    assign dbg_state = state_q;

    always_comb begin
        bus.dout = 32'd0;
        if (!reset && show && !out_of_range) begin
            bus.dout = mem[idx_sel];
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        if (!ZERO_LAT && !reset) begin
            case (state_q)
                ST_IDLE: bus.busy = req;
                ST_WAIT: bus.busy = 1'b1;
                default: bus.busy = 1'b0;
            endcase
        end
    end

    // The accept cycle in IDLE is the first busy cycle, so WAIT lasts LATENCY-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wen_d   = wen_q;
        case (state_q)
            ST_IDLE: begin
                if (req && !ZERO_LAT) begin
                    addr_d  = bus.addr;
                    din_d   = bus.din;
                    wen_d   = bus.wen;
                    cnt_d   = (LAT4 > 4'd1) ? (LAT4 - 4'd2) : 4'd0;
                    state_d = (LAT4 > 4'd1) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            din_q   <= 32'd0;
            wen_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wen_q   <= wen_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (commit && wr_mask[i]) begin
                mem[idx_sel][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: LATENCY=2 and LATENCY=0 responders checked against a word model.
module tb_data_memory_responder;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg2, dbg0;

  data_memory_responder_if bus2();
  data_memory_responder_if bus0();

  data_memory_responder #(.ADDR_WIDTH(12), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .dbg_state(dbg2)
  );
  data_memory_responder #(.ADDR_WIDTH(12), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state(dbg0)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [4096];

  // Reference word model: queue read result (pre-write), then apply byte-masked write.
  function automatic void model_access(input logic [31:0] a, input logic r,
                                       input logic [3:0] w, input logic [31:0] d);
    logic [11:0] idx;
    logic        oor;
    idx = a[13:2];
    oor = 1'b0;
`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
    oor = |a[31:14];
`endif
    if (r) exp_q.push_back(oor ? 32'd0 : model[idx]);
    if (!oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
  endfunction

  // Driver for the LATENCY=2 responder; returns once DONE has been observed and checked.
  task automatic access(input logic [31:0] a, input logic r, input logic [3:0] w,
                        input logic [31:0] d, output logic rerr);
    int busy_cycles;
    bit done;
    logic [31:0] exp;
    @(posedge clk); #1;
    bus2.addr = a; bus2.ren = r; bus2.wen = w; bus2.din = d;
    model_access(a, r, w, d);
    busy_cycles = 0;
    done = 1'b0;
    rerr = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (bus2.busy) busy_cycles++;
      else done = 1'b1;
    end
    tests_run++;
    if (!done || busy_cycles !== 2) begin
      tests_failed++;
      $display("FAIL busy_len addr=%h: got %0d busy cycles, expected 2", a, busy_cycles);
    end
`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
    rerr = bus2.range_error;
`endif
    if (r) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_empty addr=%h: got dout %h, expected queue entry", a, bus2.dout);
      end else begin
        exp = exp_q.pop_front();
        if (bus2.dout !== exp) begin
          tests_failed++;
          $display("FAIL read_data addr=%h: got %h expected %h", a, bus2.dout, exp);
        end
      end
    end
    bus2.ren = 1'b0;
    bus2.wen = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus2.addr = 32'h40; bus2.ren = 1'b1; bus2.wen = 4'd0; bus2.din = 32'd0;
    bus0.addr = 32'd0; bus0.ren = 1'b0; bus0.wen = 4'd0; bus0.din = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus2.busy);
    end
    tests_run++;
    if (bus2.dout !== 32'd0) begin
      tests_failed++; $display("FAIL reset_dout: got %h expected 0", bus2.dout);
    end
    tests_run++;
    if (dbg2 !== 2'd0) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg2);
    end
    bus2.ren = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b0 || dbg2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b state=%0d expected busy=0 state=0", bus2.busy, dbg2);
    end
  endtask

  task automatic test_write_read();
    logic rerr;
    access(32'h40, 1'b0, 4'hF, 32'h12345678, rerr);
    access(32'h40, 1'b1, 4'h0, 32'h0, rerr);
  endtask

  task automatic test_byte_mask();
    logic rerr;
    access(32'h8, 1'b0, 4'hF, 32'hAABBCCDD, rerr);
    access(32'h8, 1'b0, 4'b0101, 32'h11223344, rerr);
    access(32'h8, 1'b1, 4'h0, 32'h0, rerr);
    // Read plus write together returns the pre-write word.
    access(32'hC, 1'b0, 4'hF, 32'h01020304, rerr);
    access(32'hC, 1'b1, 4'hF, 32'hFFFFFFFF, rerr);
    access(32'hC, 1'b1, 4'h0, 32'h0, rerr);
  endtask

  task automatic test_latch();
    logic rerr;
    logic [31:0] exp;
    access(32'h80, 1'b0, 4'hF, 32'h0BADCAFE, rerr);
    @(posedge clk); #1;
    bus2.addr = 32'h40; bus2.ren = 1'b1; bus2.wen = 4'd0;
    model_access(32'h40, 1'b1, 4'h0, 32'h0);
    @(posedge clk); #1;
    bus2.addr = 32'h80;
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b1) begin
      tests_failed++; $display("FAIL latch_wait_busy: got %b expected 1", bus2.busy);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if (bus2.busy !== 1'b0 || bus2.dout !== exp) begin
      tests_failed++;
      $display("FAIL latch_read: got busy=%b dout=%h expected busy=0 dout=%h", bus2.busy, bus2.dout, exp);
    end
    bus2.ren = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic rerr;
    access(32'h10, 1'b0, 4'hF, 32'h01010101, rerr);
    // Reset during WAIT: write dropped.
    @(posedge clk); #1;
    bus2.addr = 32'h10; bus2.wen = 4'hF; bus2.din = 32'hDEADBEEF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b0) begin
      tests_failed++; $display("FAIL busy_in_reset: got %b expected 0", bus2.busy);
    end
    @(posedge clk); #1;
    reset = 1'b0; bus2.wen = 4'd0;
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b0 || dbg2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL wait_reset_idle: got busy=%b state=%0d expected busy=0 state=0", bus2.busy, dbg2);
    end
    // Reset during DONE: write dropped.
    @(posedge clk); #1;
    bus2.addr = 32'h10; bus2.wen = 4'hF; bus2.din = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (dbg2 !== 2'd2) begin
      tests_failed++; $display("FAIL done_state: got %0d expected 2", dbg2);
    end
    reset = 1'b1; bus2.wen = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dbg2 !== 2'd0) begin
      tests_failed++; $display("FAIL done_reset_idle: got %0d expected 0", dbg2);
    end
    access(32'h10, 1'b1, 4'h0, 32'h0, rerr);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    @(posedge clk); #1;
    bus2.addr = 32'h100; bus2.wen = 4'hF; bus2.din = 32'hA5A55A5A; bus2.ren = 1'b0;
    model_access(32'h100, 1'b0, 4'hF, 32'hA5A55A5A);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_done1: got busy=%b expected 0", bus2.busy);
    end
    bus2.wen = 4'd0; bus2.ren = 1'b1;
    model_access(32'h100, 1'b1, 4'h0, 32'h0);
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_accept: got busy=%b expected 1", bus2.busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus2.busy !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_wait: got busy=%b expected 1", bus2.busy);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if (bus2.busy !== 1'b0 || bus2.dout !== exp) begin
      tests_failed++;
      $display("FAIL b2b_read: got busy=%b dout=%h expected busy=0 dout=%h", bus2.busy, bus2.dout, exp);
    end
    bus2.ren = 1'b0;
  endtask

  task automatic test_random();
    logic rerr;
    logic [31:0] a;
    logic        r;
    logic [3:0]  w;
    for (int i = 0; i < 8; i++) begin
      access(32'h200 + 32'(i * 4), 1'b0, 4'hF, $urandom, rerr);
    end
    for (int i = 0; i < 12; i++) begin
      a = 32'h200 + 32'($urandom_range(0, 7) * 4);
      r = 1'($urandom_range(0, 1));
      w = 4'($urandom_range(0, 15));
      if (!r && w == 4'd0) r = 1'b1;
      access(a, r, w, $urandom, rerr);
    end
  endtask

  task automatic test_range();
    logic rerr;
    access(32'h0, 1'b0, 4'hF, 32'h0000AAAA, rerr);
    access(32'h4000, 1'b0, 4'hF, 32'h77777777, rerr);
`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
    tests_run++;
    if (rerr !== 1'b1) begin
      tests_failed++; $display("FAIL range_error_set: got %b expected 1", rerr);
    end
`endif
    access(32'h0, 1'b1, 4'h0, 32'h0, rerr);
`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
    tests_run++;
    if (rerr !== 1'b0) begin
      tests_failed++; $display("FAIL range_error_clear: got %b expected 0", rerr);
    end
`endif
    access(32'h4000, 1'b1, 4'h0, 32'h0, rerr);
  endtask

  task automatic test_zero_latency();
    logic [31:0] exp;
    @(posedge clk); #1;
    bus0.addr = 32'h4; bus0.wen = 4'hF; bus0.din = 32'h5; bus0.ren = 1'b0;
    exp_q.push_back(32'h5);
    @(negedge clk);
    tests_run++;
    if (bus0.busy !== 1'b0) begin
      tests_failed++; $display("FAIL zl_busy_write: got %b expected 0", bus0.busy);
    end
    @(posedge clk); #1;
    bus0.wen = 4'd0; bus0.ren = 1'b1;
    #1;
    exp = exp_q.pop_front();
    tests_run++;
    if (bus0.dout !== exp || bus0.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zl_read: got busy=%b dout=%h expected busy=0 dout=%h", bus0.busy, bus0.dout, exp);
    end
    @(posedge clk); #1;
    bus0.ren = 1'b0; bus0.wen = 4'b0011; bus0.din = 32'hFFFFFFFF;
    exp_q.push_back(32'h0000FFFF);
    @(posedge clk); #1;
    bus0.wen = 4'd0; bus0.ren = 1'b1;
    #1;
    exp = exp_q.pop_front();
    tests_run++;
    if (bus0.dout !== exp || bus0.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zl_mask_read: got busy=%b dout=%h expected busy=0 dout=%h", bus0.busy, bus0.dout, exp);
    end
    bus0.ren = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_latch();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_range();
    test_zero_latency();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
